// File: rtl/l1d_data_pipe_data_ram_mb.sv
// L1D data-pipe data-RAM stage: way/set/word array with 1-cycle reads,
// byte-masked writes and a circular evict buffer draining over valid/ready.
module l1d_data_pipe_data_ram_mb #(
  parameter int NUM_SET    = 64,
  parameter int NUM_WAY    = 4,
  parameter int LINE_WORDS = 8,
  parameter int DATA_W     = 64,
  parameter int EVB_DEPTH  = 4,
  parameter int ID_W       = 4,
  localparam int SET_W  = $clog2(NUM_SET),
  localparam int WAY_W  = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1,
  localparam int WRD_W  = $clog2(LINE_WORDS),
  localparam int STB_W  = DATA_W / 8,
  localparam int LINE_W = LINE_WORDS * DATA_W,
  localparam int CNT_W  = $clog2(EVB_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_ram_req_vld,
  output logic              data_ram_req_rdy,
  input  logic [1:0]        data_ram_req_op,
  input  logic [SET_W-1:0]  data_ram_req_set,
  input  logic [WAY_W-1:0]  data_ram_req_way,
  input  logic [WRD_W-1:0]  data_ram_req_word,
  input  logic [DATA_W-1:0] data_ram_req_wdat,
  input  logic [STB_W-1:0]  data_ram_req_wstrb,
  input  logic [ID_W-1:0]   data_ram_req_id,
  output logic              upstream_ack_en,
  output logic [DATA_W-1:0] upstream_ack_dat,
  output logic [ID_W-1:0]   upstream_ack_id,
  output logic              evict_vld,
  input  logic              evict_rdy,
  output logic [LINE_W-1:0] evict_dat,
  output logic [SET_W-1:0]  evict_set,
  output logic [WAY_W-1:0]  evict_way,
  output logic [ID_W-1:0]   evict_id,
  output logic [CNT_W-1:0]  evb_cnt
);

  localparam int PTR_W = $clog2(EVB_DEPTH);
  localparam logic [1:0] OP_RD = 2'd0;
  localparam logic [1:0] OP_WR = 2'd1;
  localparam logic [1:0] OP_EV = 2'd2;

  logic [DATA_W-1:0] mem [NUM_WAY][NUM_SET][LINE_WORDS];

  logic [LINE_W-1:0] evb_dat [EVB_DEPTH];
  logic [SET_W-1:0]  evb_set [EVB_DEPTH];
  logic [WAY_W-1:0]  evb_way [EVB_DEPTH];
  logic [ID_W-1:0]   evb_id  [EVB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  logic              acc;
  logic              rd_fire;
  logic              wr_fire;
  logic              ev_fire;
  logic              pop;
  logic [LINE_W-1:0] line;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    inc = (p == PTR_W'(EVB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stall depends only on the occupancy count, never on evict_rdy.
  assign data_ram_req_rdy = !(data_ram_req_op == OP_EV &&
                              cnt == CNT_W'(EVB_DEPTH));

  assign acc     = data_ram_req_vld && data_ram_req_rdy;
  assign rd_fire = acc && data_ram_req_op == OP_RD;
  assign wr_fire = acc && data_ram_req_op == OP_WR;
  assign ev_fire = acc && data_ram_req_op == OP_EV;
  assign pop     = evict_vld && evict_rdy;

  assign evb_cnt   = cnt;
  assign evict_vld = cnt != '0;
  assign evict_dat = evb_dat[rd_ptr];
  assign evict_set = evb_set[rd_ptr];
  assign evict_way = evb_way[rd_ptr];
  assign evict_id  = evb_id[rd_ptr];

  always_comb begin
    line = '0;
    for (int w = 0; w < LINE_WORDS; w++)
      line[w*DATA_W +: DATA_W] =
        mem[data_ram_req_way][data_ram_req_set][w];
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      for (int b = 0; b < STB_W; b++)
        if (data_ram_req_wstrb[b])
          mem[data_ram_req_way][data_ram_req_set]
             [data_ram_req_word][b*8 +: 8] <=
            data_ram_req_wdat[b*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upstream_ack_en  <= 1'b0;
      upstream_ack_dat <= '0;
      upstream_ack_id  <= '0;
    end else begin
      upstream_ack_en <= rd_fire;
      if (rd_fire) begin
        upstream_ack_dat <=
          mem[data_ram_req_way][data_ram_req_set][data_ram_req_word];
        upstream_ack_id  <= data_ram_req_id;
      end
    end
  end

  // Reservation and tail write share the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int e = 0; e < EVB_DEPTH; e++) begin
        evb_dat[e] <= '0;
        evb_set[e] <= '0;
        evb_way[e] <= '0;
        evb_id[e]  <= '0;
      end
    end else begin
      if (ev_fire) begin
        evb_dat[wr_ptr] <= line;
        evb_set[wr_ptr] <= data_ram_req_set;
        evb_way[wr_ptr] <= data_ram_req_way;
        evb_id[wr_ptr]  <= data_ram_req_id;
        wr_ptr          <= inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= inc(rd_ptr);
      case ({ev_fire, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_l1d_data_pipe_data_ram_mb.sv
// Scoreboard bench for l1d_data_pipe_data_ram_mb: directed reads, writes,
// evict back-pressure, pointer wrap and reset discard.
module tb_l1d_data_pipe_data_ram_mb;

  logic         clk;
  logic         rst_n;
  logic         data_ram_req_vld;
  logic         data_ram_req_rdy;
  logic [1:0]   data_ram_req_op;
  logic [5:0]   data_ram_req_set;
  logic [1:0]   data_ram_req_way;
  logic [2:0]   data_ram_req_word;
  logic [63:0]  data_ram_req_wdat;
  logic [7:0]   data_ram_req_wstrb;
  logic [3:0]   data_ram_req_id;
  logic         upstream_ack_en;
  logic [63:0]  upstream_ack_dat;
  logic [3:0]   upstream_ack_id;
  logic         evict_vld;
  logic         evict_rdy;
  logic [511:0] evict_dat;
  logic [5:0]   evict_set;
  logic [1:0]   evict_way;
  logic [3:0]   evict_id;
  logic [2:0]   evb_cnt;

  l1d_data_pipe_data_ram_mb dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .data_ram_req_vld   (data_ram_req_vld),
    .data_ram_req_rdy   (data_ram_req_rdy),
    .data_ram_req_op    (data_ram_req_op),
    .data_ram_req_set   (data_ram_req_set),
    .data_ram_req_way   (data_ram_req_way),
    .data_ram_req_word  (data_ram_req_word),
    .data_ram_req_wdat  (data_ram_req_wdat),
    .data_ram_req_wstrb (data_ram_req_wstrb),
    .data_ram_req_id    (data_ram_req_id),
    .upstream_ack_en    (upstream_ack_en),
    .upstream_ack_dat   (upstream_ack_dat),
    .upstream_ack_id    (upstream_ack_id),
    .evict_vld          (evict_vld),
    .evict_rdy          (evict_rdy),
    .evict_dat          (evict_dat),
    .evict_set          (evict_set),
    .evict_way          (evict_way),
    .evict_id           (evict_id),
    .evb_cnt            (evb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] dat;
    logic [3:0]  id;
  } ack_t;

  typedef struct packed {
    logic [511:0] dat;
    logic [5:0]   set;
    logic [1:0]   way;
    logic [3:0]   id;
  } ev_t;

  ack_t ack_q[$];
  ev_t  ev_q[$];
  logic [63:0] mdl [4][64][8];
  int checks = 0;
  int errors = 0;
  int last_waits;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mline(input int s, input int w);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = mdl[w][s][k];
    return l;
  endfunction

  always @(negedge clk) begin
    ack_t a;
    ev_t  e;
    if (rst_n) begin
      if (upstream_ack_en) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: got id %0h expected none",
                   upstream_ack_id);
        end else begin
          a = ack_q.pop_front();
          chk("ack_dat", upstream_ack_dat, a.dat);
          chk("ack_id", upstream_ack_id, a.id);
        end
      end
      if (evict_vld && evict_rdy) begin
        if (ev_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL evict_unexpected: got set %0d expected none",
                   evict_set);
        end else begin
          e = ev_q.pop_front();
          chk("evict_dat", evict_dat, e.dat);
          chk("evict_set", evict_set, e.set);
          chk("evict_way", evict_way, e.way);
          chk("evict_id", evict_id, e.id);
        end
      end
    end
  end

  // Leaves vld high so the caller can chain requests back-to-back.
  task automatic req(input logic [1:0] op, input int s, input int w,
                     input int k, input logic [63:0] wdat,
                     input logic [7:0] strb, input logic [3:0] id,
                     input logic [63:0] rexp);
    bit ok;
    ok = 0;
    last_waits = 0;
    data_ram_req_vld   = 1'b1;
    data_ram_req_op    = op;
    data_ram_req_set   = 6'(s);
    data_ram_req_way   = 2'(w);
    data_ram_req_word  = 3'(k);
    data_ram_req_wdat  = wdat;
    data_ram_req_wstrb = strb;
    data_ram_req_id    = id;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_ram_req_rdy) begin
        ok = 1;
        break;
      end
      last_waits++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no accept expected accept op %0d", op);
    end else begin
      case (op)
        2'd0: ack_q.push_back('{dat: rexp, id: id});
        2'd1:
          for (int b = 0; b < 8; b++)
            if (strb[b]) mdl[w][s][k][b*8 +: 8] = wdat[b*8 +: 8];
        2'd2: ev_q.push_back('{dat: mline(s, w), set: 6'(s),
                               way: 2'(w), id: id});
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int w, input int k,
                    input logic [63:0] d, input logic [7:0] strb);
    req(2'd1, s, w, k, d, strb, 4'h0, 64'h0);
  endtask

  task automatic rd(input int s, input int w, input int k,
                    input logic [3:0] id, input logic [63:0] exp);
    req(2'd0, s, w, k, 64'h0, 8'h0, id, exp);
  endtask

  task automatic ev(input int s, input int w, input logic [3:0] id);
    req(2'd2, s, w, 0, 64'h0, 8'h0, id, 64'h0);
  endtask

  task automatic idle();
    data_ram_req_vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && evb_cnt != 0; i++) @(negedge clk);
    chk("drain_cnt", evb_cnt, 0);
  endtask

  initial begin
    rst_n              = 1'b0;
    evict_rdy          = 1'b0;
    data_ram_req_vld   = 1'b0;
    data_ram_req_op    = 2'd0;
    data_ram_req_set   = '0;
    data_ram_req_way   = '0;
    data_ram_req_word  = '0;
    data_ram_req_wdat  = '0;
    data_ram_req_wstrb = '0;
    data_ram_req_id    = '0;
    #2;
    chk("rst_ack_en", upstream_ack_en, 0);
    chk("rst_ack_dat", upstream_ack_dat, 0);
    chk("rst_evict_vld", evict_vld, 0);
    chk("rst_evb_cnt", evb_cnt, 0);
    chk("rst_evict_dat", evict_dat, 0);
    chk("rst_req_rdy", data_ram_req_rdy, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++)
        for (int k = 0; k < 8; k++)
          wr(s, w, k, {8'(s), 8'(w), 8'(k), 40'hC0FFEE0000}, 8'hFF);

    wr(5, 2, 3, 64'h1122334455667788, 8'hFF);
    rd(5, 2, 3, 4'h7, 64'h1122334455667788);
    wr(5, 2, 3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    rd(5, 2, 3, 4'h9, 64'h11223344AAAAAAAA);
    idle();
    repeat (3) @(negedge clk);
    chk("hold_ack_en", upstream_ack_en, 0);
    chk("hold_ack_dat", upstream_ack_dat, 64'h11223344AAAAAAAA);
    chk("hold_ack_id", upstream_ack_id, 4'h9);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      ev(10 + i, 1, 4'(i));
      chk("fill_cnt", evb_cnt, i + 1);
    end
    idle();
    data_ram_req_op = 2'd2;
    #1 chk("full_rdy_evict", data_ram_req_rdy, 0);
    data_ram_req_op = 2'd0;
    #1 chk("full_rdy_read", data_ram_req_rdy, 1);
    data_ram_req_op = 2'd1;
    #1 chk("full_rdy_write", data_ram_req_rdy, 1);
    @(posedge clk);
    #1;
    evict_rdy = 1'b1;
    ev(14, 1, 4'h4);
    chk("fifth_waits", last_waits, 1);
    idle();
    drain();

    evict_rdy = 1'b0;
    @(posedge clk);
    #1;
    ev(0, 0, 4'h1);
    ev(1, 0, 4'h2);
    ev(2, 0, 4'h3);
    chk("cnt3", evb_cnt, 3);
    evict_rdy = 1'b1;
    ev(3, 0, 4'h4);
    chk("cnt3_accept_pop", evb_cnt, 3);
    for (int i = 4; i < 12; i++) ev(i, i % 4, 4'(i));
    idle();
    drain();

    wr(7, 3, 5, 64'hDEADBEEFCAFEF00D, 8'hFF);
    ev(7, 3, 4'hA);
    idle();
    chk("wr_then_evict_word", evict_dat[5*64 +: 64], 64'hDEADBEEFCAFEF00D);
    drain();

    evict_rdy = 1'b0;
    @(posedge clk);
    #1;
    ev(8, 0, 4'h1);
    ev(9, 0, 4'h2);
    rd(5, 2, 3, 4'h3, 64'h11223344AAAAAAAA);
    idle();
    chk("inflight_ack_en", upstream_ack_en, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ack_en", upstream_ack_en, 0);
    chk("arst_ack_dat", upstream_ack_dat, 0);
    chk("arst_ack_id", upstream_ack_id, 0);
    chk("arst_evict_vld", evict_vld, 0);
    chk("arst_evb_cnt", evb_cnt, 0);
    chk("arst_evict_dat", evict_dat, 0);
    ack_q.delete();
    ev_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ev(12, 2, 4'hC);
    idle();
    chk("post_rst_cnt", evb_cnt, 1);
    chk("post_rst_dat", evict_dat, mline(12, 2));
    chk("post_rst_set", evict_set, 12);
    chk("post_rst_way", evict_way, 2);
    evict_rdy = 1'b1;
    drain();

    repeat (3) @(negedge clk);
    chk("ack_q_empty", ack_q.size(), 0);
    chk("ev_q_empty", ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
